// File: rtl/sriov_vf_enable_seq.sv
// sriov_vf_enable_seq: SR-IOV VF bring-up/tear-down sequencer (settle, per-VF activation, drain, teardown).
// Optional ACTIVE-entry counter on enable_count when SRIOV_VF_SEQ_STATS_EN is defined.
module sriov_vf_enable_seq #(
    parameter int MAX_VFS       = 16,
    parameter int NUMVF_W       = 7,
    parameter int SETTLE_CYCLES = 1000,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vf_enable,
    input  logic               vf_mse,
    input  logic [NUMVF_W-1:0] num_vfs,
    input  logic [MAX_VFS-1:0] vf_np_outstanding,
    output logic [MAX_VFS-1:0] vf_active,
    output logic [MAX_VFS-1:0] vf_mem_en,
    output logic [2:0]         seq_state,
    output logic               seq_busy,
    output logic               enable_done,
    output logic               drain_timeout_err,
    output logic [7:0]         enable_count
);
    localparam int IW = (MAX_VFS > 1) ? $clog2(MAX_VFS) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        ACTIVATE = 3'd2,
        ACTIVE   = 3'd3,
        DRAIN    = 3'd4,
        TEARDOWN = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [IW-1:0]    idx;
    logic [6:0]       nvf;
    logic [6:0]       nvf_clamp;
    logic             abort;
    logic             settle_done;
    logic             enter_active;

    assign nvf_clamp    = (int'(num_vfs) > MAX_VFS) ? 7'(MAX_VFS) : 7'(num_vfs);
    assign abort        = !vf_enable && (state == SETTLE || state == ACTIVATE || state == ACTIVE);
    assign settle_done  = state == SETTLE && timer == CNT_W'(SETTLE_CYCLES - 1);
    // Shared by the FSM and the stats counter so both see the same ACTIVE entry
    assign enter_active = !abort && ((settle_done && nvf == 7'd0) ||
                                     (state == ACTIVATE && 7'(idx) == nvf - 7'd1));
    assign seq_state    = state;
    assign seq_busy     = !(state == IDLE || state == ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            timer             <= '0;
            idx               <= '0;
            nvf               <= '0;
            vf_active         <= '0;
            vf_mem_en         <= '0;
            enable_done       <= 1'b0;
            drain_timeout_err <= 1'b0;
        end else begin
            enable_done <= enter_active;
            vf_mem_en   <= vf_active & {MAX_VFS{vf_mse}};
            if (abort) begin
                state     <= DRAIN;
                timer     <= '0;
                vf_mem_en <= '0;
            end else begin
                case (state)
                    IDLE: if (vf_enable) begin
                        state             <= SETTLE;
                        nvf               <= nvf_clamp;
                        timer             <= '0;
                        drain_timeout_err <= 1'b0;
                    end
                    SETTLE: begin
                        timer <= timer + 1'b1;
                        if (settle_done) begin
                            state <= (nvf == 7'd0) ? ACTIVE : ACTIVATE;
                            idx   <= '0;
                        end
                    end
                    ACTIVATE: begin
                        vf_active[idx] <= 1'b1;
                        idx            <= idx + 1'b1;
                        if (enter_active) state <= ACTIVE;
                    end
                    ACTIVE: ;
                    DRAIN: begin
                        vf_mem_en <= '0;
                        timer     <= timer + 1'b1;
                        if ((vf_np_outstanding & vf_active) == '0) begin
                            state <= TEARDOWN;
                        end else if (timer == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                            state             <= TEARDOWN;
                            drain_timeout_err <= 1'b1;
                        end
                    end
                    TEARDOWN: begin
                        vf_active <= '0;
                        vf_mem_en <= '0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SRIOV_VF_SEQ_STATS_EN
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) cnt <= 8'h00;
        else if (enter_active && cnt != 8'hFF) cnt <= cnt + 8'h01;
    end

    assign enable_count = cnt;
`else
    assign enable_count = 8'h00;
`endif

endmodule

// File: tb/tb_sriov_vf_enable_seq.sv
// tb_sriov_vf_enable_seq: scoreboard bench; stimulus pushes expected output-change events, a negedge monitor pops and compares.
module tb_sriov_vf_enable_seq;
    localparam int NV = 16;
    localparam int S  = 8;
    localparam int D  = 16;
`ifdef SRIOV_VF_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vf_enable = 1'b0;
    logic        vf_mse = 1'b0;
    logic [6:0]  num_vfs = 7'd0;
    logic [15:0] vf_np_outstanding = 16'h0;
    logic [15:0] vf_active, vf_mem_en;
    logic [2:0]  seq_state;
    logic        seq_busy, enable_done, drain_timeout_err;
    logic [7:0]  enable_count;

    sriov_vf_enable_seq #(
        .MAX_VFS(NV), .NUMVF_W(7), .SETTLE_CYCLES(S), .DRAIN_TIMEOUT(D), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .vf_enable(vf_enable), .vf_mse(vf_mse), .num_vfs(num_vfs),
        .vf_np_outstanding(vf_np_outstanding), .vf_active(vf_active), .vf_mem_en(vf_mem_en),
        .seq_state(seq_state), .seq_busy(seq_busy), .enable_done(enable_done),
        .drain_timeout_err(drain_timeout_err), .enable_count(enable_count)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct {
        int          at;
        logic [2:0]  st;
        logic [15:0] act;
        logic [15:0] mem;
        logic        done;
        logic        err;
    } ev_t;

    ev_t         q[$];
    ev_t         e;
    int          checks = 0;
    int          errors = 0;
    int          m_act = 0;
    int          m_err = 0;
    int          m_cnt = 0;
    bit          fin = 1'b0;
    logic [36:0] cur, prev;
    logic        exp_busy;

    function automatic void push(input int at, input int st, input int act, input int mem,
                                 input int done, input int err);
        ev_t x;
        x.at   = at;
        x.st   = 3'(st);
        x.act  = 16'(act);
        x.mem  = 16'(mem);
        x.done = 1'(done);
        x.err  = 1'(err);
        q.push_back(x);
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // rst_bits > 0: assert rst after that many VF bits have appeared
    task automatic bringup(input int num, input int rst_bits, input int t0);
        int n, t, a, prv;
        n = (num > NV) ? NV : num;
        t = (t0 < 0) ? cyc : t0;
        num_vfs   = 7'(num);
        vf_mse    = 1'b1;
        vf_enable = 1'b1;
        m_err     = 0;
        push(t + 1, 1, 0, 0, 0, 0);
        if (n == 0) begin
            push(t + S + 1, 3, 0, 0, 1, 0);
            push(t + S + 2, 3, 0, 0, 0, 0);
            m_cnt++;
            m_act = 0;
            wait_until(t + S + 3);
        end else begin
            push(t + S + 1, 2, 0, 0, 0, 0);
            prv = 0;
            for (int k = 0; k < n && (rst_bits == 0 || k < rst_bits); k++) begin
                a = (1 << (k + 1)) - 1;
                push(t + S + 2 + k, (k == n - 1) ? 3 : 2, a, prv, (k == n - 1) ? 1 : 0, 0);
                prv = a;
            end
            if (rst_bits > 0) begin
                wait_until(t + S + 1 + rst_bits);
                rst       = 1'b1;
                vf_enable = 1'b0;
                m_cnt     = 0;
                m_act     = 0;
                m_err     = 0;
                wait_until(t + S + 2 + rst_bits);
                rst = 1'b0;
            end else begin
                push(t + S + 2 + n, 3, prv, prv, 0, 0);
                m_cnt++;
                m_act = prv;
                wait_until(t + S + 3 + n);
            end
        end
    endtask

    task automatic teardown(input int npv, input int h, input bit stuck, input bit reen,
                            output int t_idle);
        int t, td;
        t = cyc;
        vf_np_outstanding = 16'(npv);
        vf_enable = 1'b0;
        push(t + 1, 4, m_act, 0, 0, m_err);
        if (stuck) begin
            td    = t + D + 1;
            m_err = 1;
        end else begin
            td = t + ((h > 1) ? h : 1) + 1;
        end
        push(td, 5, m_act, 0, 0, m_err);
        push(td + 1, 0, 0, 0, 0, m_err);
        m_act = 0;
        if (reen) begin
            wait_until(t + 2);
            vf_enable = 1'b1;
        end
        if (!stuck) begin
            wait_until(t + h);
            vf_np_outstanding = 16'h0;
        end
        wait_until(td + 1);
        vf_np_outstanding = 16'h0;
        t_idle = td + 1;
    endtask

    always @(negedge clk) begin
        cur = {seq_state, vf_active, vf_mem_en, enable_done, drain_timeout_err};
        if (rst_q) begin
            checks++;
            if (cur !== 37'h0 || seq_busy !== 1'b0 || enable_count !== 8'h00) begin
                errors++;
                $display("FAIL reset_state cycle=%0d got st=%0d act=%h mem=%h done=%b err=%b busy=%b cnt=%0d required all zero",
                         cyc, seq_state, vf_active, vf_mem_en, enable_done, drain_timeout_err, seq_busy, enable_count);
            end
            prev = cur;
        end else begin
            while (q.size() > 0 && q[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event required at cycle=%0d st=%0d act=%h mem=%h, not seen by cycle %0d",
                         q[0].at, q[0].st, q[0].act, q[0].mem, cyc);
                void'(q.pop_front());
            end
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cycle=%0d got st=%0d act=%h mem=%h done=%b err=%b required no change",
                             cyc, seq_state, vf_active, vf_mem_en, enable_done, drain_timeout_err);
                end else begin
                    e = q.pop_front();
                    exp_busy = !(e.st == 3'd0 || e.st == 3'd3);
                    if (e.at != cyc || {e.st, e.act, e.mem, e.done, e.err} !== cur || seq_busy !== exp_busy) begin
                        errors++;
                        $display("FAIL event got cycle=%0d st=%0d act=%h mem=%h done=%b err=%b busy=%b required cycle=%0d st=%0d act=%h mem=%h done=%b err=%b busy=%b",
                                 cyc, seq_state, vf_active, vf_mem_en, enable_done, drain_timeout_err, seq_busy,
                                 e.at, e.st, e.act, e.mem, e.done, e.err, exp_busy);
                    end
                end
                prev = cur;
            end
            if (fin) begin
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL pending_events got %0d left required 0", q.size());
                end
                checks++;
                if (enable_count !== (STATS ? 8'(m_cnt) : 8'h00)) begin
                    errors++;
                    $display("FAIL enable_count got %0d required %0d", enable_count, STATS ? m_cnt : 0);
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        int ti, t;
        wait_until(3);
        rst = 1'b0;
        // nominal bring-up, then vf_mse toggles and an ignored num_vfs change
        bringup(4, 0, -1);
        t = cyc;
        vf_mse = 1'b0;
        push(t + 1, 3, m_act, 0, 0, 0);
        wait_until(t + 1);
        t = cyc;
        vf_mse = 1'b1;
        push(t + 1, 3, m_act, m_act, 0, 0);
        wait_until(t + 2);
        num_vfs = 7'd9;
        wait_until(cyc + 3);
        teardown(16'h0002, 5, 1'b0, 1'b0, ti);
        // clamp to MAX_VFS, then drain timeout
        bringup(40, 0, -1);
        teardown(16'h0001, 0, 1'b1, 1'b0, ti);
        // zero VFs, clears the sticky timeout flag
        bringup(0, 0, -1);
        teardown(0, 0, 1'b0, 1'b0, ti);
        // abort during SETTLE at timer == 3
        t = cyc;
        num_vfs   = 7'd4;
        vf_mse    = 1'b1;
        vf_enable = 1'b1;
        m_err     = 0;
        push(t + 1, 1, 0, 0, 0, 0);
        wait_until(t + 4);
        teardown(0, 0, 1'b0, 1'b0, ti);
        // vf_enable re-asserted during DRAIN only takes effect from IDLE
        bringup(4, 0, -1);
        teardown(16'h0002, 5, 1'b0, 1'b1, ti);
        bringup(3, 0, ti);
        teardown(0, 0, 1'b0, 1'b0, ti);
        // reset mid-ACTIVATE after two bits
        bringup(4, 2, -1);
        wait_until(cyc + 2);
        // three enable/disable rounds for the stats counter
        for (int r = 0; r < 3; r++) begin
            bringup(1, 0, -1);
            teardown(0, 0, 1'b0, 1'b0, ti);
        end
        wait_until(cyc + 5);
        fin = 1'b1;
        #1000;
        $display("FAIL summary_not_reached");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1);
    end

endmodule
